// File: rtl/mc_pkg.sv
// Shared definitions for the memory controller: state encoding and counter width.
// Every mem_controller source file imports this package.
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        READ   = 2'b10,
        WRITE  = 2'b11
    } state_t;

    localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/mc_state_decode.sv
// Moore output decode for the memory controller.
// Every output depends on the registered state alone, so the strobes cannot glitch.
module mc_state_decode
    import mc_pkg::*;
(
    input  state_t state,
    output logic   mem_read,
    output logic   mem_write,
    output logic   active,
    output logic   status,
    output logic   req_ready
);

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        active    = 1'b0;
        status    = 1'b0;
        req_ready = 1'b0;
        case (state)
            IDLE:   req_ready = 1'b1;
            ACTIVE: active    = 1'b1;
            READ: begin
                mem_read = 1'b1;
                status   = 1'b1;
            end
            WRITE: begin
                mem_write = 1'b1;
                status    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_controller.sv
// Single-port memory controller: accepts one request in IDLE, holds the selected strobe
// for LATENCY cycles, then pulses done with the captured read data.
module mem_controller
    import mc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  active,
    output logic                  status,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam logic [CNT_WIDTH-1:0] COUNT_LOAD = CNT_WIDTH'(LATENCY - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] count;
    logic                 wr_flag;
    logic                 last_cycle;

    assign last_cycle = ((state == READ) || (state == WRITE)) && (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ACTIVE;
            ACTIVE:  state_next = wr_flag ? WRITE : READ;
            READ,
            WRITE:   if (count == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latches, wait counter, completion pulse and read capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            wr_flag   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            rdata     <= '0;
        end else begin
            done <= last_cycle;
            if (state == IDLE && req_valid) begin
                wr_flag   <= req_write;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
            if (state == ACTIVE)
                count <= COUNT_LOAD;
            else if (count != '0)
                count <= count - 1'b1;
            if (state == READ && count == '0)
                rdata <= mem_rdata;
        end
    end

    mc_state_decode u_decode (
        .state     (state),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .active    (active),
        .status    (status),
        .req_ready (req_ready)
    );

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller: three instances (LATENCY 3, 1, 4) checked every
// cycle against a transaction-timeline model, plus a vector table and directed corner cases.
module tb_mem_controller;

    localparam int NI = 3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 3 : (g == 1) ? 1 : 4;
    endfunction

    logic        clk = 1'b0;
    logic        reset_v     [NI];
    logic        req_valid_v [NI];
    logic        req_ready_v [NI];
    logic        req_write_v [NI];
    logic [7:0]  req_addr_v  [NI];
    logic [31:0] req_wdata_v [NI];
    logic [7:0]  mem_addr_v  [NI];
    logic [31:0] mem_wdata_v [NI];
    logic [31:0] mem_rdata_v [NI];
    logic        mem_read_v  [NI];
    logic        mem_write_v [NI];
    logic        active_v    [NI];
    logic        status_v    [NI];
    logic        done_v      [NI];
    logic [31:0] rdata_v     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(lat_of(g))) u_dut (
            .clk       (clk),
            .reset     (reset_v[g]),
            .req_valid (req_valid_v[g]),
            .req_ready (req_ready_v[g]),
            .req_write (req_write_v[g]),
            .req_addr  (req_addr_v[g]),
            .req_wdata (req_wdata_v[g]),
            .mem_addr  (mem_addr_v[g]),
            .mem_wdata (mem_wdata_v[g]),
            .mem_rdata (mem_rdata_v[g]),
            .mem_read  (mem_read_v[g]),
            .mem_write (mem_write_v[g]),
            .active    (active_v[g]),
            .status    (status_v[g]),
            .done      (done_v[g]),
            .rdata     (rdata_v[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[inst %0d] @%0t: got %h, want %h", name, inst, $time, act, exp);
        end
    endtask

    // Timeline model: k counts cycles since acceptance (1 = ACTIVE, 2..L+1 = strobe).
    bit          m_busy  [NI];
    int          m_k     [NI];
    bit          m_wr    [NI];
    bit          m_done  [NI];
    logic [7:0]  m_addr  [NI];
    logic [31:0] m_wdata [NI];
    logic [31:0] m_rdata [NI];

    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            if (reset_v[i]) begin
                m_busy[i] = 0; m_k[i] = 0; m_wr[i] = 0; m_done[i] = 0;
                m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i] = '0;
            end else begin
                m_done[i] = 0;
                if (m_busy[i]) begin
                    if (m_k[i] == lat_of(i) + 1) begin
                        m_busy[i] = 0;
                        m_done[i] = 1;
                        if (!m_wr[i]) m_rdata[i] = mem_rdata_v[i];
                    end else begin
                        m_k[i]++;
                    end
                end else if (req_valid_v[i]) begin
                    m_busy[i]  = 1;
                    m_k[i]     = 1;
                    m_wr[i]    = req_write_v[i];
                    m_addr[i]  = req_addr_v[i];
                    m_wdata[i] = req_wdata_v[i];
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            bit strobe;
            strobe = m_busy[i] && (m_k[i] >= 2);
            check("req_ready", i, 64'(req_ready_v[i]), 64'(!m_busy[i]));
            check("active",    i, 64'(active_v[i]),    64'(m_busy[i] && m_k[i] == 1));
            check("status",    i, 64'(status_v[i]),    64'(strobe));
            check("mem_read",  i, 64'(mem_read_v[i]),  64'(strobe && !m_wr[i]));
            check("mem_write", i, 64'(mem_write_v[i]), 64'(strobe && m_wr[i]));
            check("done",      i, 64'(done_v[i]),      64'(m_done[i]));
            check("rdata",     i, 64'(rdata_v[i]),     64'(m_rdata[i]));
            check("mem_addr",  i, 64'(mem_addr_v[i]),  64'(m_addr[i]));
            check("mem_wdata", i, 64'(mem_wdata_v[i]), 64'(m_wdata[i]));
            check("strobe_excl", i, 64'(mem_read_v[i] && mem_write_v[i]), 64'(0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            req_valid_v[i] = 0; req_write_v[i] = 0;
            req_addr_v[i] = '0; req_wdata_v[i] = '0; mem_rdata_v[i] = '0;
        end
    endtask

    // Inputs drive cycle c; expectations are the outputs during cycle c+1.
    typedef struct {
        bit          valid;
        bit          write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        bit          ready, act, rd, wr, dn;
        logic [7:0]  maddr;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        tbl[0] = '{1, 0, 8'h12, 32'h0,        32'h11111111, 0, 1, 0, 0, 0, 8'h12, 32'h0};
        tbl[1] = '{1, 1, 8'h77, 32'hFFFFFFFF, 32'h11111111, 0, 0, 1, 0, 0, 8'h12, 32'h0};
        tbl[2] = '{0, 0, 8'h34, 32'h0,        32'h11111111, 0, 0, 1, 0, 0, 8'h12, 32'h0};
        tbl[3] = '{1, 0, 8'h56, 32'h0,        32'h11111111, 0, 0, 1, 0, 0, 8'h12, 32'h0};
        tbl[4] = '{0, 0, 8'h12, 32'h0,        32'hDEADBEEF, 1, 0, 0, 0, 1, 8'h12, 32'hDEADBEEF};
        tbl[5] = '{0, 0, 8'h12, 32'h0,        32'h00000000, 1, 0, 0, 0, 0, 8'h12, 32'hDEADBEEF};

        // Reset held two cycles, then idle.
        idle_inputs();
        for (int i = 0; i < NI; i++) reset_v[i] = 1;
        tick();
        tick();
        for (int i = 0; i < NI; i++) reset_v[i] = 0;
        tick();
        for (int i = 0; i < NI; i++) begin
            check("rst_ready", i, 64'(req_ready_v[i]), 64'(1));
            check("rst_rdata", i, 64'(rdata_v[i]), 64'(0));
            check("rst_strobes", i, 64'({mem_read_v[i], mem_write_v[i], active_v[i], done_v[i]}), 64'(0));
        end

        // Read on LATENCY=3 with interference on req_* during the strobe.
        for (int v = 0; v < 6; v++) begin
            req_valid_v[0] = tbl[v].valid; req_write_v[0] = tbl[v].write;
            req_addr_v[0] = tbl[v].addr; req_wdata_v[0] = tbl[v].wdata;
            mem_rdata_v[0] = tbl[v].mrdata;
            tick();
            check("tbl_ready",  v, 64'(req_ready_v[0]), 64'(tbl[v].ready));
            check("tbl_active", v, 64'(active_v[0]),    64'(tbl[v].act));
            check("tbl_read",   v, 64'(mem_read_v[0]),  64'(tbl[v].rd));
            check("tbl_write",  v, 64'(mem_write_v[0]), 64'(tbl[v].wr));
            check("tbl_done",   v, 64'(done_v[0]),      64'(tbl[v].dn));
            check("tbl_maddr",  v, 64'(mem_addr_v[0]),  64'(tbl[v].maddr));
            check("tbl_rdata",  v, 64'(rdata_v[0]),     64'(tbl[v].rdata));
        end
        idle_inputs();
        tick();

        // LATENCY=1: a read to give rdata a value, then a write that must leave it alone.
        req_valid_v[1] = 1; req_write_v[1] = 0; req_addr_v[1] = 8'h03;
        tick();
        req_valid_v[1] = 0;
        tick();
        mem_rdata_v[1] = 32'hCAFEF00D;
        tick();
        check("l1_read_done", 1, 64'(done_v[1]), 64'(1));
        mem_rdata_v[1] = 32'h0;
        req_valid_v[1] = 1; req_write_v[1] = 1; req_addr_v[1] = 8'h05; req_wdata_v[1] = 32'hA5A5A5A5;
        tick();
        check("l1_active", 1, 64'(active_v[1]), 64'(1));
        req_valid_v[1] = 0; req_wdata_v[1] = 32'h0;
        tick();
        check("l1_write_on", 1, 64'(mem_write_v[1]), 64'(1));
        check("l1_wdata", 1, 64'(mem_wdata_v[1]), 64'hA5A5A5A5);
        check("l1_addr", 1, 64'(mem_addr_v[1]), 64'h05);
        tick();
        check("l1_write_off", 1, 64'(mem_write_v[1]), 64'(0));
        check("l1_write_done", 1, 64'(done_v[1]), 64'(1));
        check("l1_rdata_kept", 1, 64'(rdata_v[1]), 64'hCAFEF00D);
        tick();

        // Back-to-back on LATENCY=3: valid held high, write then read.
        req_valid_v[0] = 1; req_write_v[0] = 1; req_addr_v[0] = 8'h40; req_wdata_v[0] = 32'h12345678;
        tick();
        n = 0;
        while (!done_v[0] && n < 20) begin tick(); n++; end
        check("b2b_first_done", 0, 64'(done_v[0]), 64'(1));
        req_write_v[0] = 0; req_addr_v[0] = 8'h41;
        tick();
        check("b2b_accept", 0, 64'(active_v[0]), 64'(1));
        check("b2b_addr", 0, 64'(mem_addr_v[0]), 64'h41);
        req_valid_v[0] = 0;
        n = 0;
        while (!done_v[0] && n < 20) begin tick(); n++; end
        check("b2b_second_done", 0, 64'(done_v[0]), 64'(1));
        idle_inputs();
        tick();

        // Reset during the second WRITE strobe cycle on LATENCY=4.
        req_valid_v[2] = 1; req_write_v[2] = 1; req_addr_v[2] = 8'h9C; req_wdata_v[2] = 32'h0BADF00D;
        tick();
        req_valid_v[2] = 0;
        tick();
        tick();
        check("rmw_in_write", 2, 64'(mem_write_v[2]), 64'(1));
        reset_v[2] = 1;
        tick();
        reset_v[2] = 0;
        check("rmw_ready", 2, 64'(req_ready_v[2]), 64'(1));
        check("rmw_write_off", 2, 64'(mem_write_v[2]), 64'(0));
        check("rmw_done0", 2, 64'(done_v[2]), 64'(0));
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rmw_no_done", 2, 64'(done_v[2]), 64'(0));
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                req_valid_v[i] = ($urandom % 3) != 0;
                req_write_v[i] = $urandom % 2;
                req_addr_v[i]  = 8'($urandom);
                req_wdata_v[i] = $urandom;
                mem_rdata_v[i] = $urandom;
                reset_v[i]     = ($urandom % 150) == 0;
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < NI; i++) reset_v[i] = 0;
        for (int c = 0; c < 8; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_controller.md
MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, address bits; DATA_WIDTH, default 32, data bits; LATENCY, default 2, memory strobe hold cycles, legal range 1..255.
REQ-002 Clock and reset SHALL be: clk  in  1  single clock, all state on rising edge; reset  in  1  synchronous, active-high.
REQ-003 req_valid  in  1  requester presents a transaction.
REQ-004 req_ready  out  1  controller accepts a transaction this cycle.
REQ-005 req_write  in  1  transaction type: 1 = write, 0 = read.
REQ-006 req_addr  in  ADDR_WIDTH  transaction address.
REQ-007 req_wdata  in  DATA_WIDTH  write data.
REQ-008 mem_addr  out  ADDR_WIDTH  latched address to memory.
REQ-009 mem_wdata  out  DATA_WIDTH  latched write data to memory.
REQ-010 mem_rdata  in  DATA_WIDTH  memory read data, valid in the final READ cycle.
REQ-011 mem_read  out  1  read strobe.
REQ-012 mem_write  out  1  write strobe.
REQ-013 active  out  1  controller is in ACTIVE.
REQ-014 status  out  1  busy: controller is in READ or WRITE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 rdata  out  DATA_WIDTH  captured read data.

Function
REQ-017 The FSM SHALL have exactly four states, encoded IDLE=00, ACTIVE=01, READ=10, WRITE=11.
REQ-018 The outputs mem_read, mem_write, active, status and req_ready SHALL be decoded from the state register only (Moore): req_ready=IDLE, active=ACTIVE, mem_read=READ, mem_write=WRITE, status=READ|WRITE.
REQ-019 IDLE SHALL go to ACTIVE on req_valid=1. At that edge it SHALL latch req_write, req_addr into mem_addr, and req_wdata into mem_wdata.
REQ-020 IDLE SHALL stay in IDLE while req_valid=0.
REQ-021 ACTIVE SHALL last exactly one cycle, then go to WRITE if the latched write flag is 1, else to READ. On that edge the wait counter SHALL be loaded with LATENCY-1.
REQ-022 READ and WRITE SHALL each last exactly LATENCY cycles: the counter decrements each cycle, and on count==0 the FSM returns to IDLE.
REQ-023 On the READ-to-IDLE edge, rdata SHALL capture mem_rdata. rdata SHALL otherwise hold its value, including across writes.
REQ-024 done SHALL be a registered pulse, high for exactly the one cycle following the last READ or WRITE cycle; rdata is valid in that same cycle.
REQ-025 Latency from the accepting edge to done high SHALL be LATENCY+2 cycles. A new request SHALL be acceptable in the done cycle, so the throughput is one transaction per LATENCY+2 cycles.
REQ-026 req_valid and all req_* inputs SHALL be ignored outside IDLE. mem_addr and mem_wdata SHALL stay stable from ACTIVE through the final strobe cycle.
REQ-027 mem_read and mem_write SHALL never be high together. Strobes SHALL be glitch-free, since they are decoded from registered state only.
REQ-028 The counter width SHALL be 8 bits, and no wrap SHALL occur because the count stops at 0.

Reset
REQ-029 reset=1 at a rising edge SHALL force state=IDLE, counter=0, done=0, rdata=0, mem_addr=0, mem_wdata=0 and write flag=0.
REQ-030 After that edge the outputs SHALL be req_ready=1 and active=status=mem_read=mem_write=0.
REQ-031 Reset asserted mid-transaction SHALL abort it: no done pulse, and rdata is not updated.
REQ-032 Reset SHALL take priority over req_valid in the same cycle.

Structure
REQ-033 The state encoding constants IDLE/ACTIVE/READ/WRITE and the 2-bit state type SHALL live in the shared package mc_pkg.
REQ-034 The Moore output decode SHALL be one sub-module, mc_state_decode: 2-bit state in; mem_read, mem_write, active, status, req_ready out; purely combinational.
REQ-035 The state register, counter, data latches and done register SHALL reside in mem_controller.

Verification
REQ-036 Reset then idle: hold reset 2 cycles, then release -> req_ready=1, all strobes 0, rdata=0, done=0.
REQ-037 Read, LATENCY=3: request addr=0x12, mem_rdata=0xDEADBEEF -> active in cycle 1, mem_read in cycles 2-4 with mem_addr=0x12, done and rdata=0xDEADBEEF in cycle 5.
REQ-038 Write, LATENCY=1: request addr=0x05, wdata=0xA5A5A5A5 -> mem_write for exactly 1 cycle with mem_wdata=0xA5A5A5A5, done 1 cycle later, rdata unchanged.
REQ-039 Back-to-back: req_valid held high, write then read -> second request accepted in the first request's done cycle, and mem_read/mem_write are never high together.
REQ-040 Interference: toggle req_valid and req_addr during READ -> mem_addr unchanged and no extra transaction occurs.
REQ-041 Reset mid-WRITE in the 2nd strobe cycle with LATENCY=4 -> IDLE next cycle, mem_write=0, no done pulse.
